// File: rtl/wb_unit.sv
// Writeback stage: retires ALU results and at most one outstanding load into the register file.
// Optional WB_ERR_EN adds a sticky err output for protocol anomalies.
module wb_unit #(
  parameter int LOAD_TIMEOUT = 0,
  parameter int TO_W         = 8
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_ad,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_ad,
  output logic [31:0] rf_rd,
  output logic        pend_valid,
  output logic [4:0]  pend_ad
`ifdef WB_ERR_EN
  ,
  output logic        err
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]      state;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_lo;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic            take;
  logic            timeout;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;

  assign ex_ready   = (state == IDLE);
  assign pend_valid = (state == WAIT_LOAD);
  assign take       = ex_valid & ex_ready;
  assign to_nxt     = to_cnt + TO_W'(1);

  // rvalid on the expiring cycle takes priority, so timeout requires !rvalid
  assign timeout = (LOAD_TIMEOUT != 0) && (state == WAIT_LOAD) && !dmem_rvalid &&
                   (to_nxt == TO_W'(LOAD_TIMEOUT));

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (ld_lo)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = ld_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_f3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state   <= IDLE;
      rf_we   <= 1'b0;
      rf_ad   <= 5'd0;
      rf_rd   <= 32'd0;
      pend_ad <= 5'd0;
      ld_f3   <= 3'd0;
      ld_lo   <= 2'd0;
      to_cnt  <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (ex_is_load) begin
              state   <= WAIT_LOAD;
              pend_ad <= ex_ad;
              ld_f3   <= ex_funct3;
              ld_lo   <= ex_addr_lo;
              to_cnt  <= '0;
            end else begin
              rf_we <= (ex_ad != 5'd0);
              rf_ad <= ex_ad;
              rf_rd <= ex_result;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            state <= IDLE;
            rf_we <= (pend_ad != 5'd0);
            rf_ad <= pend_ad;
            rf_rd <= ld_ext;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_ERR_EN
  always_ff @(posedge clk) begin
    if (!resetb)
      err <= 1'b0;
    else if ((state == IDLE && dmem_rvalid) || timeout ||
             (take && ex_is_load && (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11)))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed plus randomized ALU/load traffic against a
// behavioural extension model; LOAD_TIMEOUT=4 so the timeout path is exercised.
module tb_wb_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_ad = '0;
  logic [31:0] ex_result = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_addr_lo = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_ad;
  logic [31:0] rf_rd;
  logic        pend_valid;
  logic [4:0]  pend_ad;
`ifdef WB_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  wb_unit #(.LOAD_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .resetb(resetb), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_ad(ex_ad), .ex_result(ex_result),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_ad(rf_ad), .rf_rd(rf_rd),
    .pend_valid(pend_valid), .pend_ad(pend_ad)
`ifdef WB_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load result from the ISA rules: shift the addressed lane down, mask, extend.
  function automatic logic [31:0] model_ext(input int f3, input int a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      1:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      4:       return b;
      5:       return h;
      default: return d;
    endcase
  endfunction

  task automatic do_reset;
    resetb = 1'b0;
    ex_valid = 1'b0;
    dmem_rvalid = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({rf_we, rf_ad, rf_rd, pend_valid, pend_ad, ex_ready} !==
        {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got we=%0b ad=%0d rd=%h pv=%0b pad=%0d rdy=%0b, expected all 0 with rdy=1",
               rf_we, rf_ad, rf_rd, pend_valid, pend_ad, ex_ready);
    end
`ifdef WB_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
`endif
  endtask

  // Back-to-back ALU ops, one per cycle; first is the directed ad=5 case.
  task automatic test_alu;
    logic [4:0]  ad;
    logic [31:0] res;
    for (int i = 0; i < 20; i++) begin
      ad  = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
      res = (i == 0) ? 32'h1234_5678 : $urandom;
      ex_valid = 1'b1; ex_is_load = 1'b0; ex_ad = ad; ex_result = res;
      checks++;
      if (ex_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0b expected 1", ex_ready); end
      tick();
      checks++;
      if ({rf_we, rf_ad, rf_rd} !== {1'b1, ad, res}) begin
        errors++;
        $display("FAIL alu_write[%0d]: got we=%0b ad=%0d rd=%h expected we=1 ad=%0d rd=%h",
                 i, rf_we, rf_ad, rf_rd, ad, res);
      end
    end
    ex_valid = 1'b0;
    tick();
    checks++;
    if ({rf_we, rf_ad, rf_rd} !== {1'b0, ad, res}) begin
      errors++;
      $display("FAIL alu_idle: got we=%0b ad=%0d rd=%h expected we=0 ad=%0d rd=%h",
               rf_we, rf_ad, rf_rd, ad, res);
    end
  endtask

  task automatic test_x0;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_ad = 5'd0; ex_result = 32'hFFFF_FFFF;
    tick();
    ex_valid = 1'b0;
    checks++;
    if ({rf_we, rf_ad, rf_rd} !== {1'b0, 5'd0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL x0_suppress: got we=%0b ad=%0d rd=%h expected we=0 ad=0 rd=ffffffff",
               rf_we, rf_ad, rf_rd);
    end
  endtask

  // Directed extension vectors, then random loads with 0..3 idle wait cycles.
  task automatic test_load;
    int d_f3[5] = '{0, 4, 1, 5, 2};
    int d_a[5]  = '{3, 3, 2, 2, 0};
    int f3, a, waits;
    logic [4:0]  ad;
    logic [31:0] data, exp;
    for (int i = 0; i < 35; i++) begin
      if (i < 5) begin
        f3 = d_f3[i]; a = d_a[i]; data = 32'h80FF_0102; ad = 5'd3; waits = 1;
      end else begin
        f3 = $urandom_range(0, 7); a = $urandom_range(0, 3); data = $urandom;
        ad = 5'($urandom_range(0, 31)); waits = $urandom_range(0, 3);
      end
      exp = model_ext(f3, a, data);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_ad = ad;
      ex_funct3 = 3'(f3); ex_addr_lo = 2'(a); ex_result = $urandom;
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      for (int w = 0; w < waits; w++) begin
        checks++;
        if ({pend_valid, pend_ad, ex_ready, rf_we} !== {1'b1, ad, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL load_wait[%0d]: got pv=%0b pad=%0d rdy=%0b we=%0b expected pv=1 pad=%0d rdy=0 we=0",
                   i, pend_valid, pend_ad, ex_ready, rf_we, ad);
        end
        tick();
      end
      dmem_rvalid = 1'b1; dmem_rdata = data;
      checks++;
      if (ex_ready !== 1'b0) begin errors++; $display("FAIL load_rvalid_ready[%0d]: got %0b expected 0", i, ex_ready); end
      tick();
      dmem_rvalid = 1'b0;
      checks++;
      if ({rf_we, rf_ad, rf_rd, pend_valid, ex_ready} !== {ad != 5'd0, ad, exp, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL load_write[%0d] f3=%0d a=%0d data=%h: got we=%0b ad=%0d rd=%h pv=%0b rdy=%0b expected we=%0b ad=%0d rd=%h pv=0 rdy=1",
                 i, f3, a, data, rf_we, rf_ad, rf_rd, pend_valid, ex_ready, ad != 5'd0, ad, exp);
      end
    end
  endtask

  task automatic test_stall;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_ad = 5'd7; ex_funct3 = 3'd2; ex_addr_lo = 2'd0;
    tick();
    ex_is_load = 1'b0; ex_ad = 5'd11; ex_result = 32'hCAFE_0011;
    for (int w = 0; w < 3; w++) begin
      if (w == 2) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
      checks++;
      if ({pend_valid, pend_ad, ex_ready} !== {1'b1, 5'd7, 1'b0}) begin
        errors++;
        $display("FAIL stall_wait[%0d]: got pv=%0b pad=%0d rdy=%0b expected pv=1 pad=7 rdy=0",
                 w, pend_valid, pend_ad, ex_ready);
      end
      tick();
    end
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_ad, rf_rd, ex_ready} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1}) begin
      errors++;
      $display("FAIL stall_load_write: got we=%0b ad=%0d rd=%h rdy=%0b expected we=1 ad=7 rd=deadbeef rdy=1",
               rf_we, rf_ad, rf_rd, ex_ready);
    end
    tick();
    ex_valid = 1'b0;
    checks++;
    if ({rf_we, rf_ad, rf_rd} !== {1'b1, 5'd11, 32'hCAFE_0011}) begin
      errors++;
      $display("FAIL stall_alu_write: got we=%0b ad=%0d rd=%h expected we=1 ad=11 rd=cafe0011",
               rf_we, rf_ad, rf_rd);
    end
  endtask

  task automatic test_reset_mid_load;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_ad = 5'd9; ex_funct3 = 3'd2;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, pend_valid, ex_ready} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_load: got we=%0b pv=%0b rdy=%0b expected we=0 pv=0 rdy=1",
               rf_we, pend_valid, ex_ready);
    end
  endtask

  task automatic test_timeout;
    // rvalid on the 4th wait cycle still writes
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_ad = 5'd14; ex_funct3 = 3'd2;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    for (int w = 0; w < TO - 1; w++) tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_ad, rf_rd, pend_valid} !== {1'b1, 5'd14, 32'h0BAD_F00D, 1'b0}) begin
      errors++;
      $display("FAIL timeout_edge_write: got we=%0b ad=%0d rd=%h pv=%0b expected we=1 ad=14 rd=0badf00d pv=0",
               rf_we, rf_ad, rf_rd, pend_valid);
    end
    // no rvalid: abandoned after TO wait cycles
    do_reset();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_ad = 5'd12; ex_funct3 = 3'd2;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    for (int w = 0; w < TO; w++) begin
      checks++;
      if ({pend_valid, ex_ready, rf_we} !== {1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got pv=%0b rdy=%0b we=%0b expected pv=1 rdy=0 we=0",
                 w, pend_valid, ex_ready, rf_we);
      end
      tick();
    end
    checks++;
    if ({pend_valid, ex_ready, rf_we} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL timeout_expire: got pv=%0b rdy=%0b we=%0b expected pv=0 rdy=1 we=0",
               pend_valid, ex_ready, rf_we);
    end
`ifdef WB_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b expected 1", err); end
`endif
  endtask

  task automatic test_rvalid_idle;
    do_reset();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, pend_valid, ex_ready} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rvalid_idle: got we=%0b pv=%0b rdy=%0b expected we=0 pv=0 rdy=1",
               rf_we, pend_valid, ex_ready);
    end
`ifdef WB_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rvalid_idle_err: got %0b expected 1", err); end
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", err); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_x0();
    test_load();
    test_stall();
    test_reset_mid_load();
    test_timeout();
    test_rvalid_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
